score_digit_renderer: RTL
=========================

# score_digit_renderer

Renders the player score as a row of scaled 5x5 digit glyphs for the color mapper. Accepts a binary score load, converts it to BCD with a sequential double-dabble engine, and per pixel maps DrawX/DrawY to a glyph request (digit, row, col). The request goes to the digit-glyph lookup in the sprite table. The block registers the returned palette index as a 2-cycle-latency pixel stream.

## Interface
- NUM_DIGITS, 5: digits displayed, most significant digit leftmost.
- SCORE_W, 17: binary score width.
- ORIGIN_X, 10'd480: left pixel of the score field.
- ORIGIN_Y, 10'd64: top pixel of the score field.
- SCALE_LOG2, 2: glyph expansion, 2^SCALE_LOG2 screen pixels per glyph cell.
- Clk, in, 1: system clock.
- Reset_n, in, 1: asynchronous, active-low reset.
- score_in, in, SCORE_W: binary score, sampled when score_load is high.
- score_load, in, 1: single-cycle load strobe.
- DrawX, in, 10: current pixel column.
- DrawY, in, 10: current pixel row.
- glyph_digit, out, 4: digit value 0-9 requested from the glyph lookup.
- glyph_row, out, 3: glyph row 0-4.
- glyph_col, out, 3: glyph column 0-4.
- glyph_pix, in, 4: palette index returned combinationally for the current glyph request.
- score_pix, out, 4: palette index. 0 means transparent.
- score_on, out, 1: pixel lies inside a glyph cell with a nonzero index.
- busy, out, 1: conversion in progress.

## Operation
- Conversion FSM states: IDLE, SHIFT, COMMIT.
- IDLE + score_load:
  - Capture min(score_in, 10^NUM_DIGITS − 1). Values above 99999 saturate to 99999.
  - Clear the working BCD register and go to SHIFT.
- SHIFT:
  - Runs SCORE_W cycles.
  - Each cycle adds 3 to every working nibble ≥5, then shifts the BCD:binary pair left by 1.
  - A bit counter wraps to 0 and moves the FSM to COMMIT.
- COMMIT:
  - Copy the working BCD to the display register in one cycle.
  - Go to IDLE, or directly to SHIFT when a pending load exists.
- score_load while busy:
  - Store score_in in the pending register and set pending. A later load overwrites it (last value wins).
  - The conversion in progress is never aborted.
- Display register changes only in COMMIT, so no mid-frame glyph tearing.
- Pixel mapping, with rx = DrawX − ORIGIN_X and ry = DrawY − ORIGIN_Y (unsigned 10-bit):
  - cx = rx >> SCALE_LOG2; cy = ry >> SCALE_LOG2.
  - Digit slot = cx[..:3] (8-cell pitch: 5 glyph + 3 gap).
  - glyph_col = cx[2:0]; glyph_row = cy[2:0].
- A pixel is in-field when all hold: DrawX ≥ ORIGIN_X, DrawY ≥ ORIGIN_Y, slot < NUM_DIGITS, col < 5, row < 5.
- Slot s maps to BCD digit NUM_DIGITS−1−s.
- Out-of-field pixels force stage-2 score_pix = 0 and score_on = 0. glyph_* still carry the computed values, which are don't-care.

## Timing
- Reset: FSM IDLE, display BCD all zero, pending = 0, busy = 0, glyph_digit/row/col = 0, score_pix = 0, score_on = 0.
- busy rises the cycle after the accepted load and stays high for SCORE_W + 1 cycles (SHIFT + COMMIT).
- The display register holds the new value SCORE_W + 2 cycles after the load strobe.
- Pending load: SHIFT re-enters straight from COMMIT, so busy stays high continuously.
- Pixel pipeline:
  - Cycle t: DrawX/DrawY sampled.
  - t+1: glyph_digit/row/col and an in-field flag registered.
  - t+2: score_pix/score_on registered from glyph_pix and the delayed flag.
- score_load does not stall the pixel pipeline.
- Reset mid-conversion: everything returns to reset values immediately; the pending load is discarded.

## Configuration
- SCORE_LZB_EN defined: leading-zero blanking. A slot is transparent when its digit and all more-significant digits are zero; the least significant slot always renders. Example: 42 shows as "42".
- SCORE_LZB_EN undefined: all NUM_DIGITS slots render; 42 shows as "00042".

## Structure
- Package tetris_score_pkg holds:
  - bcd_t (4-bit digit type).
  - conv_state_t enum {IDLE, SHIFT, COMMIT}.
  - Constants GLYPH_DIM = 5 and DIGIT_PITCH_LOG2 = 3.
- Sub-module bcd_double_dabble contains the FSM, working and pending registers, and the bit counter. It outputs the display BCD vector and busy.
- The top level does pixel mapping, digit select, and the two pipeline stages.

## Test plan
- Reset, then DrawX = 480, DrawY = 64 → two cycles later, glyph request (digit 0, row 0, col 0) and score_pix = glyph_pix stub value; busy = 0.
- Load 12345 → busy high 18 cycles; after 19 cycles display BCD = 1,2,3,4,5; pixel at slot 2 (DrawX = 480 + 64) requests digit 3.
- Load 131071 → display saturates to 9,9,9,9,9.
- Load 100, then load 7 during SHIFT, then load 8 during SHIFT → display shows 100, then 8; 7 is never committed; busy stays continuous.
- DrawX = 480 + 5·4 (gap column) and DrawX = 480 + 40·4 (past last slot) → score_on = 0, score_pix = 0.
- With SCORE_LZB_EN, load 42 → slots 0-2 transparent, slots 3-4 request digits 4 and 2; load 0 → only slot 4 renders, digit 0.

Source files
------------

// File: rtl/tetris_score_pkg.sv
// Shared types and constants for the score digit renderer and its
// double-dabble BCD converter.
package tetris_score_pkg;

    // Glyphs are GLYPH_DIM x GLYPH_DIM cells on an 8-cell horizontal pitch.
    localparam int GLYPH_DIM        = 5;
    localparam int DIGIT_PITCH_LOG2 = 3;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_state_t;

    // Largest value representable with the given number of decimal digits.
    function automatic longint max_decimal(input int digits);
        longint r;
        r = 1;
        for (int i = 0; i < digits; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

    // Double-dabble correction: a nibble of 5 or more would overflow past 9
    // after the next doubling, so bias it by 3 first.
    function automatic bcd_t dabble_adjust(input bcd_t d);
        return (d >= 4'd5) ? bcd_t'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bcd_double_dabble.sv
// Sequential binary-to-BCD converter (shift-and-add-3). Holds the conversion
// FSM, the working BCD:binary pair, a one-deep pending load and the display
// register that only changes in COMMIT so the renderer never sees a partial
// result.
module bcd_double_dabble
    import tetris_score_pkg::*;
#(
    parameter int NUM_DIGITS = 5,
    parameter int SCORE_W    = 17
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [SCORE_W-1:0]      score_in,
    input  logic                    score_load,
    output logic [4*NUM_DIGITS-1:0] display_bcd,
    output logic                    busy
);

    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int PAIR_W = BCD_W + SCORE_W;
    localparam int CNT_W  = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SCORE_W - 1);
    localparam longint SCORE_MAX = max_decimal(NUM_DIGITS);

    // Clamp to the largest value the digit row can show.
    function automatic logic [SCORE_W-1:0] saturate(input logic [SCORE_W-1:0] v);
        if (longint'({1'b0, v}) > SCORE_MAX) begin
            return SCORE_W'(SCORE_MAX);
        end
        return v;
    endfunction

    conv_state_t          state_q, state_d;
    logic [SCORE_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]     work_q, work_d;
    logic [SCORE_W-1:0]   pend_val_q, pend_val_d;
    logic                 pend_q, pend_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [BCD_W-1:0]     display_q, display_d;
    logic                 busy_q, busy_d;
    logic [BCD_W-1:0]     adj;
    logic [PAIR_W-1:0]    pair;

    // Next-state logic for the conversion FSM, pending slot and display.
    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise
        // the paths that do not assign it would infer a latch.
        state_d    = state_q;
        bin_d      = bin_q;
        work_d     = work_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        bit_cnt_d  = bit_cnt_q;
        display_d  = display_q;
        adj        = work_q;
        pair       = {work_q, bin_q};

        // A load that arrives while a conversion runs is parked; a newer one
        // replaces it. COMMIT below may consume it in the same cycle.
        if (state_q != IDLE && score_load) begin
            pend_d     = 1'b1;
            pend_val_d = score_in;
        end

        case (state_q)
            IDLE: begin
                if (score_load) begin
                    bin_d     = saturate(score_in);
                    work_d    = '0;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    adj[4*i +: 4] = dabble_adjust(work_q[4*i +: 4]);
                end
                pair   = {adj, bin_q} << 1;
                work_d = pair[PAIR_W-1 -: BCD_W];
                bin_d  = pair[SCORE_W-1:0];
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    state_d   = COMMIT;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end

            COMMIT: begin
                display_d = work_q;
                if (score_load || pend_q) begin
                    bin_d     = saturate(score_load ? score_in : pend_val_q);
                    work_d    = '0;
                    bit_cnt_d = '0;
                    pend_d    = 1'b0;
                    state_d   = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers; reset also drops any pending load.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            work_q     <= '0;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            bit_cnt_q  <= '0;
            display_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q    <= state_d;
            bin_q      <= bin_d;
            work_q     <= work_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            bit_cnt_q  <= bit_cnt_d;
            display_q  <= display_d;
            busy_q     <= busy_d;
        end
    end

    assign display_bcd = display_q;
    assign busy        = busy_q;

endmodule

// File: rtl/score_digit_renderer.sv
// Score digit renderer: converts a binary score to BCD (bcd_double_dabble)
// and maps each pixel to a glyph request (digit, row, col). The palette index
// returned by the glyph lookup is registered as a 2-cycle pixel stream.
// Optional build macro SCORE_LZB_EN enables leading-zero blanking.
module score_digit_renderer
    import tetris_score_pkg::*;
#(
    parameter int         NUM_DIGITS = 5,
    parameter int         SCORE_W    = 17,
    parameter logic [9:0] ORIGIN_X   = 10'd480,
    parameter logic [9:0] ORIGIN_Y   = 10'd64,
    parameter int         SCALE_LOG2 = 2
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [SCORE_W-1:0] score_in,
    input  logic               score_load,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    output logic [3:0]         glyph_digit,
    output logic [2:0]         glyph_row,
    output logic [2:0]         glyph_col,
    input  logic [3:0]         glyph_pix,
    output logic [3:0]         score_pix,
    output logic               score_on,
    output logic               busy
);

    localparam int         BCD_W        = 4 * NUM_DIGITS;
    localparam logic [9:0] NUM_SLOTS    = 10'(NUM_DIGITS);
    localparam logic [2:0] GLYPH_DIM_W  = 3'(GLYPH_DIM);

    logic [BCD_W-1:0]      display_bcd;
    logic [NUM_DIGITS-1:0] lz_blank;

    bcd_double_dabble #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCORE_W    (SCORE_W)
    ) u_conv (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .score_in    (score_in),
        .score_load  (score_load),
        .display_bcd (display_bcd),
        .busy        (busy)
    );

`ifdef SCORE_LZB_EN
    logic seen_nonzero;

    // Blank a digit while it and everything more significant are zero; the
    // least significant digit is never blanked so zero still shows as "0".
    always_comb begin
        lz_blank     = '0;
        seen_nonzero = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (display_bcd[4*i +: 4] != 4'd0) begin
                seen_nonzero = 1'b1;
            end
            lz_blank[i] = !seen_nonzero;
        end
    end
`else
    assign lz_blank = '0;
`endif

    // Pixel -> cell mapping. Offsets wrap as 10-bit values; the explicit
    // origin compares reject pixels left of / above the field.
    logic [9:0] slot_c;
    logic [2:0] col_c;
    logic [2:0] row_c;
    logic       geo_in_c;

    assign slot_c = 10'((DrawX - ORIGIN_X) >> (SCALE_LOG2 + DIGIT_PITCH_LOG2));
    assign col_c  = 3'((DrawX - ORIGIN_X) >> SCALE_LOG2);
    assign row_c  = 3'((DrawY - ORIGIN_Y) >> SCALE_LOG2);

    assign geo_in_c = (DrawX >= ORIGIN_X) && (DrawY >= ORIGIN_Y) &&
                      (slot_c < NUM_SLOTS) && (col_c < GLYPH_DIM_W) &&
                      (row_c < GLYPH_DIM_W);

    logic [3:0] glyph_digit_q, glyph_digit_d;
    logic [2:0] glyph_row_q, glyph_row_d;
    logic [2:0] glyph_col_q, glyph_col_d;
    logic       vis_q, vis_d;
    logic [3:0] score_pix_q, score_pix_d;
    logic       score_on_q, score_on_d;
    logic       blank_c;

    // Stage 1 selects the digit for the slot (leftmost slot = most
    // significant); stage 2 gates the returned palette index.
    always_comb begin
        glyph_digit_d = 4'd0;
        blank_c       = 1'b0;
        for (int s = 0; s < NUM_DIGITS; s++) begin
            if (slot_c == 10'(s)) begin
                glyph_digit_d = display_bcd[4*(NUM_DIGITS-1-s) +: 4];
                blank_c       = lz_blank[NUM_DIGITS-1-s];
            end
        end
        glyph_row_d = row_c;
        glyph_col_d = col_c;
        vis_d       = geo_in_c && !blank_c;

        score_pix_d = vis_q ? glyph_pix : 4'd0;
        score_on_d  = vis_q && (glyph_pix != 4'd0);
    end

    // Two-stage pixel pipeline registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            glyph_digit_q <= 4'd0;
            glyph_row_q   <= 3'd0;
            glyph_col_q   <= 3'd0;
            vis_q         <= 1'b0;
            score_pix_q   <= 4'd0;
            score_on_q    <= 1'b0;
        end else begin
            glyph_digit_q <= glyph_digit_d;
            glyph_row_q   <= glyph_row_d;
            glyph_col_q   <= glyph_col_d;
            vis_q         <= vis_d;
            score_pix_q   <= score_pix_d;
            score_on_q    <= score_on_d;
        end
    end

    assign glyph_digit = glyph_digit_q;
    assign glyph_row   = glyph_row_q;
    assign glyph_col   = glyph_col_q;
    assign score_pix   = score_pix_q;
    assign score_on    = score_on_q;

endmodule
